ebc_readout_sequencer: RTL and testbench

Sequences address-event readout for the pixel arbiter `top_arb`.
- Gates the arbiter's enable and captures each row/column grant pair as an address.
- Timestamps the event, acknowledges the granted pixel until its request clears, and queues events in a small FIFO.
- The FIFO drains to the downstream link over a valid/ready handshake.
- Sits between `top_arb` and the event output interface.

---
 rtl/ebc_readout_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ebc_readout_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebc_readout_sequencer.sv
// Address-event readout sequencer for top_arb: gates the arbiter, captures one-hot
// row/column grants with a timestamp, acknowledges the pixel and queues events.
module ebc_readout_sequencer #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLR_TIMEOUT = 15,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int EW   = TS_WIDTH + RW + CW,
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [ROWS-1:0][COLS-1:0] req_i,
    input  logic [ROWS-1:0]           x_gnt_i,
    input  logic [COLS-1:0]           y_gnt_i,
    output logic                      arb_en_o,
    output logic [ROWS-1:0][COLS-1:0] ack_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [EW-1:0]             evt_data_o,
    output logic [CNTW-1:0]           fifo_cnt_o,
    output logic                      err_o
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int TOW = $clog2(CLR_TIMEOUT + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
    localparam logic [TOW-1:0]  TO_LAST  = TOW'(CLR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_cap_q;
    logic [RW-1:0]       row_q, row_idx;
    logic [CW-1:0]       col_q, col_idx;
    logic [TOW-1:0]      wait_q;
    logic                err_q;

    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]     cnt_q;

    logic x_onehot, y_onehot, grant_ok, grant_bad;
    logic capture, grant_err, clr_timeout;
    logic fifo_full, push, pop, req_hit;

    // A grant is usable only when both axes select exactly one line.
    assign x_onehot  = (x_gnt_i != '0) && ((x_gnt_i & (x_gnt_i - ROWS'(1))) == '0);
    assign y_onehot  = (y_gnt_i != '0) && ((y_gnt_i & (y_gnt_i - COLS'(1))) == '0);
    assign grant_ok  = x_onehot && y_onehot;
    assign grant_bad = ((x_gnt_i != '0) && !x_onehot) || ((y_gnt_i != '0) && !y_onehot);

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (x_gnt_i[i]) row_idx = RW'(i);
        end
    end

    always_comb begin
        col_idx = '0;
        for (int j = 0; j < COLS; j++) begin
            if (y_gnt_i[j]) col_idx = CW'(j);
        end
    end

    assign fifo_full   = (cnt_q == FULL_CNT);
    assign evt_valid_o = (cnt_q != '0);
    assign pop         = evt_valid_o && evt_ready_i;
    assign push        = (state_q == ACK) && !fifo_full;
    assign req_hit     = req_i[row_q][col_q];

    // A pop in the same cycle makes room, so a full FIFO does not stall the arbiter.
    assign arb_en_o = reset && (state_q == IDLE) && enable && (!fifo_full || pop);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        grant_err   = 1'b0;
        clr_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en_o) begin
                    if (grant_ok) begin
                        capture = 1'b1;
                        state_d = ACK;
                    end else if (grant_bad) begin
                        grant_err = 1'b1;
                    end
                end
            end
            ACK: state_d = WAIT_CLR;
            WAIT_CLR: begin
                if (!req_hit) begin
                    state_d = IDLE;
                end else if (wait_q == TO_LAST) begin
                    clr_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_o = '0;
        if (state_q != IDLE) ack_o[row_q][col_q] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + TS_WIDTH'(1);
            if (grant_err || clr_timeout) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q    <= '0;
            col_q    <= '0;
            ts_cap_q <= '0;
        end else if (capture) begin
            row_q    <= row_idx;
            col_q    <= col_idx;
            ts_cap_q <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (state_q == ACK) begin
            wait_q <= '0;
        end else if (state_q == WAIT_CLR) begin
            wait_q <= wait_q + TOW'(1);
        end
    end

    // NOTE: the storage array has no reset; emptiness is carried by the count,
    // and the output is gated so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {ts_cap_q, row_q, col_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign evt_data_o = evt_valid_o ? mem[rd_ptr_q] : '0;
    assign fifo_cnt_o = cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ebc_readout_sequencer.sv
// Self-checking bench for ebc_readout_sequencer: directed scenarios plus randomized
// events, checked against a transaction-level scoreboard and cycle-count timestamp.
module tb_ebc_readout_sequencer;

    localparam int ROWS        = 4;
    localparam int COLS        = 4;
    localparam int TS_WIDTH    = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int CLR_TIMEOUT = 8;
    localparam int EW          = TS_WIDTH + 2 + 2;

    logic                      clk   = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      enable = 1'b1;
    logic [ROWS-1:0][COLS-1:0] req;
    logic [ROWS-1:0]           x_gnt;
    logic [COLS-1:0]           y_gnt;
    logic                      arb_en;
    logic [ROWS-1:0][COLS-1:0] ack;
    logic                      evt_valid;
    logic                      evt_ready;
    logic [EW-1:0]             evt_data;
    logic [2:0]                fifo_cnt;
    logic                      err;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    bit            err_exp = 1'b0;
    bit            rand_ready = 1'b0;
    logic [EW-1:0] exp_q [$];

    ebc_readout_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .TS_WIDTH(TS_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .CLR_TIMEOUT(CLR_TIMEOUT)
    ) dut (
        .clk(clk), .reset(rst_n), .enable(enable), .req_i(req),
        .x_gnt_i(x_gnt), .y_gnt_i(y_gnt), .arb_en_o(arb_en), .ack_o(ack),
        .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_data_o(evt_data),
        .fifo_cnt_o(fifo_cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference timestamp: clock edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [ROWS*COLS-1:0] pix(input int r, input int c);
        logic [ROWS*COLS-1:0] v;
        v = '0;
        v[r*COLS+c] = 1'b1;
        return v;
    endfunction

    function automatic bit arb_model();
        int n;
        n = exp_q.size();
        return enable && ((n < FIFO_DEPTH) || ((n > 0) && evt_ready));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_data", 32'(evt_data), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_arb_en", 32'(arb_en), 32'd0);
        exp_q.delete();
        err_exp = 1'b0;
        req = '0; x_gnt = '0; y_gnt = '0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic present(input int r, input int c, output bit took, output bit was_empty);
        req = '0;
        req[r][c] = 1'b1;
        x_gnt = ROWS'(1) << r;
        y_gnt = COLS'(1) << c;
        #1;
        took      = arb_model();
        was_empty = (exp_q.size() == 0);
        check("arb_en_idle", 32'(arb_en), 32'(took));
        check("fifo_cnt_idle", 32'(fifo_cnt), exp_q.size());
        if (took) exp_q.push_back({TS_WIDTH'(cyc), 2'(r), 2'(c)});
    endtask

    // hold = cycles the request stays high counting from the first ack cycle.
    task automatic serve(input int r, input int c, input int hold, input bit was_empty,
                         input bit drop_en);
        int ack_cyc  = 0;
        int hold_eff = (hold < 1) ? 1 : hold;
        int exp_len  = 1 + ((hold_eff < CLR_TIMEOUT) ? hold_eff : CLR_TIMEOUT);
        for (int k = 1; k <= 20; k++) begin
            tick();
            x_gnt = '0;
            y_gnt = '0;
            if (k == 1 && drop_en) enable = 1'b0;
            if (k >= hold + 1) req[r][c] = 1'b0;
            #1;
            if (k == 1 && was_empty) check("valid_ack_cycle", 32'(evt_valid), 32'd0);
            if (k == 2 && was_empty) check("valid_two_after", 32'(evt_valid), 32'd1);
            if (ack == '0) break;
            check("ack_pixel", 32'(ack), 32'(pix(r, c)));
            check("arb_en_busy", 32'(arb_en), 32'd0);
            ack_cyc++;
        end
        if (hold_eff > CLR_TIMEOUT) err_exp = 1'b1;
        check("ack_len", ack_cyc, exp_len);
        check("err_after_evt", 32'(err), 32'(err_exp));
        check("arb_en_after", 32'(arb_en), 32'(arb_model()));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(tag, exp_q.size(), 0);
        check("drain_cnt", 32'(fifo_cnt), 32'd0);
    endtask

    initial begin
        bit took, empty, drop;
        int r, c, hold;

        req = '0; x_gnt = '0; y_gnt = '0; evt_ready = 1'b0;
        apply_reset();
        check("arb_en_out_of_reset", 32'(arb_en), 32'(arb_model()));

        // Single event at pixel (0,2), ack held for three cycles.
        evt_ready = 1'b1;
        present(0, 2, took, empty);
        serve(0, 2, 2, empty, 1'b0);
        drain("single_drained");

        // Backpressure: fill the FIFO, a fifth grant is ignored, then drain in order.
        tick();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            present(r, c, took, empty);
            serve(r, c, 1, empty, 1'b0);
            tick();
        end
        check("bp_cnt", 32'(fifo_cnt), exp_q.size());
        check("bp_arb_en", 32'(arb_en), 32'(arb_model()));
        present(1, 1, took, empty);
        tick();
        req = '0; x_gnt = '0; y_gnt = '0;
        #1;
        check("bp_fifth_ack", 32'(ack), 32'd0);
        check("bp_fifth_err", 32'(err), 32'(err_exp));
        check("bp_fifth_cnt", 32'(fifo_cnt), exp_q.size());
        evt_ready = 1'b1;
        #1;
        check("pop_frees_arb_en", 32'(arb_en), 32'(arb_model()));
        drain("bp_drained");

        // Row grant without a column grant: neither a capture nor an error.
        tick();
        x_gnt = 4'b0010; y_gnt = '0;
        #1;
        check("yzero_arb_en", 32'(arb_en), 32'(arb_model()));
        tick();
        #1;
        check("yzero_ack", 32'(ack), 32'd0);
        check("yzero_err", 32'(err), 32'(err_exp));

        // Invalid grant: ignored while disabled, flagged once enabled.
        tick();
        enable = 1'b0;
        x_gnt = 4'b0011; y_gnt = 4'b0001;
        #1;
        check("inv_dis_arb_en", 32'(arb_en), 32'(arb_model()));
        tick();
        #1;
        check("inv_dis_err", 32'(err), 32'(err_exp));
        enable = 1'b1;
        #1;
        check("inv_arb_en", 32'(arb_en), 32'(arb_model()));
        tick();
        err_exp = 1'b1;
        #1;
        check("inv_err", 32'(err), 32'(err_exp));
        check("inv_ack", 32'(ack), 32'd0);
        check("inv_cnt", 32'(fifo_cnt), exp_q.size());
        tick();
        x_gnt = '0; y_gnt = '0;

        // Clear timeout from a clean error state; event is still delivered.
        apply_reset();
        evt_ready = 1'b1;
        present(3, 1, took, empty);
        serve(3, 1, 12, empty, 1'b0);
        drain("timeout_drained");

        // Timestamp wrap: capture at 15, then at 3 after the wrap.
        tick();
        req = '0;
        for (int i = 0; i < 40; i++) begin
            if ((cyc % 16) == 15) break;
            tick();
        end
        check("ts_align_f", cyc % 16, 15);
        present(2, 3, took, empty);
        serve(2, 3, 1, empty, 1'b0);
        tick();
        for (int i = 0; i < 40; i++) begin
            if ((cyc % 16) == 3) break;
            tick();
        end
        check("ts_align_3", cyc % 16, 3);
        present(1, 0, took, empty);
        serve(1, 0, 1, empty, 1'b0);
        drain("wrap_drained");

        // Randomized events with random ready, enable and hold times.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            r      = $urandom_range(0, ROWS - 1);
            c      = $urandom_range(0, COLS - 1);
            hold   = $urandom_range(1, 10);
            enable = ($urandom_range(0, 3) != 0);
            drop   = ($urandom_range(0, 4) == 0);
            present(r, c, took, empty);
            if (took) begin
                serve(r, c, hold, empty, drop);
            end else begin
                tick();
                x_gnt = '0; y_gnt = '0;
                #1;
                check("ignored_ack", 32'(ack), 32'd0);
                check("ignored_err", 32'(err), 32'(err_exp));
            end
            req = '0;
        end
        rand_ready = 1'b0;
        tick();
        evt_ready = 1'b1;
        enable = 1'b1;
        drain("random_drained");

        // Reset while in WAIT_CLR with two events queued aborts everything at once.
        tick();
        evt_ready = 1'b0;
        present(0, 0, took, empty);
        serve(0, 0, 1, empty, 1'b0);
        tick();
        present(3, 3, took, empty);
        tick();
        x_gnt = '0; y_gnt = '0;
        tick();
        #1;
        check("two_queued", 32'(fifo_cnt), exp_q.size());
        check("wait_clr_ack", 32'(ack), 32'(pix(3, 3)));
        apply_reset();
        #1;
        check("post_rst_arb_en", 32'(arb_en), 32'(arb_model()));
        check("post_rst_cnt", 32'(fifo_cnt), exp_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
